// File: rtl/id_stage_pipe_pkg.sv
// RV32I decode types shared by the ID stage: IF/ID and ID/EX payloads, control word,
// register-use helper and the load opcode used by load-use detection.
package id_stage_pipe_pkg;

    typedef enum logic [6:0] {
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111,
        OP_BR    = 7'b1100011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_IMM   = 7'b0010011,
        OP_OP    = 7'b0110011
    } opcode_t;

    localparam logic [6:0] LOAD_OPCODE = OP_LOAD;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
    } rvfi_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        rvfi_t       rvfi_d;
    } IF_ID_stage_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       funct7_5;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_imm;
    } ctrl_t;

    // Valid bit lives beside the payload, not inside it.
    typedef struct packed {
        logic [31:0] pc;
        ctrl_t       ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] b_imm;
        logic [31:0] u_imm;
        logic [31:0] j_imm;
        rvfi_t       rvfi;
    } ID_EX_stage_t;

    typedef struct packed {
        logic rs1;
        logic rs2;
    } rs_use_t;

    function automatic rs_use_t rs_used(input logic [6:0] op);
        rs_use_t u;
        u.rs1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
        u.rs2 = op inside {OP_OP, OP_STORE, OP_BR};
        return u;
    endfunction

    function automatic ctrl_t control_word(input logic [31:0] ir);
        ctrl_t c;
        c          = '0;
        c.opcode   = ir[6:0];
        c.funct3   = ir[14:12];
        c.funct7_5 = ir[30];
        case (ir[6:0])
            OP_LUI, OP_AUIPC: begin c.reg_write = 1'b1; c.alu_imm = 1'b1; end
            OP_JAL:           begin c.reg_write = 1'b1; c.jump = 1'b1; end
            OP_JALR:          begin c.reg_write = 1'b1; c.jump = 1'b1; c.alu_imm = 1'b1; end
            OP_BR:            c.branch = 1'b1;
            OP_LOAD:          begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_imm = 1'b1; end
            OP_STORE:         begin c.mem_write = 1'b1; c.alu_imm = 1'b1; end
            OP_IMM:           begin c.reg_write = 1'b1; c.alu_imm = 1'b1; end
            OP_OP:            c.reg_write = 1'b1;
            default:          ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Load-use detector: flags an ID instruction that needs a register the load sitting
// in ID/EX has not produced yet.
module id_hazard_unit
    import id_stage_pipe_pkg::*;
#(
    parameter int HAZARD_EN = 1
) (
    input  logic       valid_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  rs_use_t    use_i,
    input  logic       ex_valid_i,
    input  logic       ex_load_i,
    input  logic [4:0] ex_rd_i,
    output logic       hazard_o
);

    assign hazard_o = (HAZARD_EN != 0) && valid_i && ex_valid_i && ex_load_i &&
                      (ex_rd_i != '0) &&
                      ((use_i.rs1 && (rs1_i == ex_rd_i)) || (use_i.rs2 && (rs2_i == ex_rd_i)));

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: decodes IF/ID, reads the regfile (with WB write-through), and owns the
// ID/EX register with flow control, load-use bubbles, flush squash and perf counters.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int WB_BYPASS = 1,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  IF_ID_stage_t      id_in,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic              flush_i,
    input  logic              ex_ready_i,
    input  logic              wb_load_i,
    input  logic [AW-1:0]     wb_rd_i,
    input  logic [31:0]       wb_data_i,
    output ID_EX_stage_t      ex_out,
    output logic              ex_valid_o,
    output logic [CNT_W-1:0]  perf_stall_o,
    output logic [CNT_W-1:0]  perf_flush_o
);

    logic [31:0]      regs_q [NUM_REGS];
    ID_EX_stage_t     ex_q, ex_d;
    logic             ex_vld_q;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic [31:0]      ir, rs1_data, rs2_data;
    logic [AW-1:0]    rs1_a, rs2_a;
    rs_use_t          rs_use;
    logic             hazard;

    assign ir    = id_in.ir;
    assign rs1_a = ir[15 +: AW];
    assign rs2_a = ir[20 +: AW];

    // WB writes land at the edge; the bypass makes the same-cycle value visible to ID.
    always_comb begin
        rs1_data = regs_q[rs1_a];
        rs2_data = regs_q[rs2_a];
        if (WB_BYPASS != 0 && wb_load_i && wb_rd_i == rs1_a) rs1_data = wb_data_i;
        if (WB_BYPASS != 0 && wb_load_i && wb_rd_i == rs2_a) rs2_data = wb_data_i;
        if (rs1_a == '0) rs1_data = '0;
        if (rs2_a == '0) rs2_data = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_load_i && wb_rd_i != '0) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    always_comb begin
        ex_d                = '0;
        ex_d.pc             = id_in.pc;
        ex_d.ctrl           = control_word(ir);
        ex_d.rd             = ir[11:7];
        ex_d.rs1            = ir[19:15];
        ex_d.rs2            = ir[24:20];
        ex_d.rs1_data       = rs1_data;
        ex_d.rs2_data       = rs2_data;
        ex_d.i_imm          = {{20{ir[31]}}, ir[31:20]};
        ex_d.s_imm          = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        ex_d.b_imm          = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        ex_d.u_imm          = {ir[31:12], 12'b0};
        ex_d.j_imm          = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        ex_d.rvfi           = id_in.rvfi_d;
        ex_d.rvfi.inst      = ir;
        ex_d.rvfi.rs1_addr  = ir[19:15];
        ex_d.rvfi.rs2_addr  = ir[24:20];
        ex_d.rvfi.rs1_rdata = rs1_data;
        ex_d.rvfi.rs2_rdata = rs2_data;
        ex_d.rvfi.rd_addr   = ir[11:7];
    end

    assign rs_use = rs_used(ir[6:0]);

    id_hazard_unit #(.HAZARD_EN(HAZARD_EN)) u_hazard (
        .valid_i    (id_valid_i),
        .rs1_i      (ir[19:15]),
        .rs2_i      (ir[24:20]),
        .use_i      (rs_use),
        .ex_valid_i (ex_vld_q),
        .ex_load_i  (ex_q.ctrl.opcode == LOAD_OPCODE),
        .ex_rd_i    (ex_q.rd),
        .hazard_o   (hazard)
    );

    assign id_ready_o = flush_i | (ex_ready_i & ~hazard);

    // Flush outranks backpressure and hazard; a flushed cycle never counts as a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q     <= '0;
            ex_vld_q <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else if (flush_i) begin
            ex_vld_q <= 1'b0;
            if (ex_vld_q && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
        end else if (ex_ready_i) begin
            if (hazard) begin
                ex_vld_q <= 1'b0;
                ex_q     <= '0;
                if (stall_q != '1) stall_q <= stall_q + CNT_W'(1);
            end else begin
                ex_vld_q <= id_valid_i;
                ex_q     <= ex_d;
            end
        end
    end

    assign ex_out       = ex_q;
    assign ex_valid_o   = ex_vld_q;
    assign perf_stall_o = stall_q;
    assign perf_flush_o = flush_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized and directed bench for id_stage_pipe against a cycle-level reference model.
module tb_id_stage_pipe;
    import id_stage_pipe_pkg::*;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    IF_ID_stage_t    id_in;
    logic            id_valid_i, id_ready_o, flush_i, ex_ready_i, wb_load_i;
    logic [4:0]      wb_rd_i;
    logic [31:0]     wb_data_i;
    ID_EX_stage_t    ex_out;
    logic            ex_valid_o;
    logic [CW-1:0]   perf_stall_o, perf_flush_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.NUM_REGS(32), .WB_BYPASS(1), .HAZARD_EN(1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_in(id_in), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i), .wb_load_i(wb_load_i), .wb_rd_i(wb_rd_i),
        .wb_data_i(wb_data_i), .ex_out(ex_out), .ex_valid_o(ex_valid_o),
        .perf_stall_o(perf_stall_o), .perf_flush_o(perf_flush_o)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    bit          m_vld, m_ld;
    logic [4:0]  m_rd;
    logic [31:0] m_pc, m_r1, m_r2, m_inst;
    logic [31:0] m_imm [5];
    int          m_stall, m_flush;
    logic [31:0] pc_ctr = 32'h1000;
    logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (wb_load_i && wb_rd_i == r) return wb_data_i;
        return m_regs[r];
    endfunction

    function automatic bit m_hazard();
        int op = int'(id_in.ir[6:0]);
        bit u1 = !(op == 'h37 || op == 'h17 || op == 'h6f);
        bit u2 = (op == 'h33 || op == 'h23 || op == 'h63);
        return id_valid_i && m_vld && m_ld && m_rd != 0 &&
               ((u1 && id_in.ir[19:15] == m_rd) || (u2 && id_in.ir[24:20] == m_rd));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_vld = 0; m_ld = 0; m_rd = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic m_edge();
        logic [31:0] w = id_in.ir;
        bit hz = m_hazard();
        if (flush_i) begin
            if (m_vld && m_flush < SAT) m_flush++;
            m_vld = 0;
        end else if (ex_ready_i) begin
            if (hz) begin
                m_vld = 0; m_ld = 0;
                if (m_stall < SAT) m_stall++;
            end else begin
                m_vld  = id_valid_i;
                m_ld   = (w[6:0] == 7'h03);
                m_rd   = w[11:7];
                m_pc   = id_in.pc;
                m_inst = w;
                m_r1   = m_read(w[19:15]);
                m_r2   = m_read(w[24:20]);
                m_imm[0] = sx(int'(w >> 20), 12);
                m_imm[1] = sx(int'(w >> 25) * 32 + int'(w[11:7]), 12);
                m_imm[2] = 2 * sx(int'(w[31]) * 2048 + int'(w[7]) * 1024 + int'(w[30:25]) * 16 + int'(w[11:8]), 12);
                m_imm[3] = w & 32'hFFFFF000;
                m_imm[4] = 2 * sx(int'(w[31]) * 524288 + int'(w[19:12]) * 2048 + int'(w[20]) * 1024 + int'(w[30:21]), 20);
            end
        end
        if (wb_load_i && wb_rd_i != 0) m_regs[wb_rd_i] = wb_data_i;
    endtask

    // Every rising edge goes through here so the model sees the same inputs as the DUT.
    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h000, rs1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 8)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic drive(input logic [31:0] ir, input bit v);
        id_in.ir      = ir;
        id_in.pc      = pc_ctr;
        id_in.rvfi_d  = '0;
        id_in.rvfi_d.pc_rdata = pc_ctr;
        id_valid_i    = v;
        pc_ctr        = pc_ctr + 4;
    endtask

    task automatic idle();
        id_valid_i = 0; flush_i = 0; wb_load_i = 0; ex_ready_i = 1;
        wb_rd_i = 0; wb_data_i = 0;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
        idle();
        wb_load_i = 1; wb_rd_i = r; wb_data_i = v;
        tick();
        wb_load_i = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 0;
        idle();
        drive(32'h13, 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", ex_valid_o); end
        n_vec++; if (ex_out !== '0) begin n_err++; $display("FAIL reset_payload: got %h exp 0", ex_out); end
        n_vec++; if (perf_stall_o !== '0 || perf_flush_o !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", perf_stall_o, perf_flush_o); end
        n_vec++; if (id_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", id_ready_o); end
        @(negedge clk);
        rst = 1;
        tick();
    endtask

    task automatic test_load_use();
        wb_write(1, 32'h100);
        wb_write(2, 32'd7);
        drive(enc_lw(5, 1), 1);
        tick();
        n_vec++; if (ex_valid_o !== 1'b1 || ex_out.ctrl.mem_read !== 1'b1 || ex_out.rd !== 5'd5)
            begin n_err++; $display("FAIL lu_load: got v=%b ld=%b rd=%0d exp 1/1/5", ex_valid_o, ex_out.ctrl.mem_read, ex_out.rd); end
        n_vec++; if (ex_out.rvfi.rs1_rdata !== 32'h100) begin n_err++; $display("FAIL lu_load_rs1: got %h exp 100", ex_out.rvfi.rs1_rdata); end
        drive(enc_add(6, 5, 2), 1);
        @(negedge clk);
        n_vec++; if (id_ready_o !== 1'b0) begin n_err++; $display("FAIL lu_ready_stall: got %b exp 0", id_ready_o); end
        tick();
        n_vec++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got %b exp 0", ex_valid_o); end
        n_vec++; if (perf_stall_o !== 4'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d exp 1", perf_stall_o); end
        @(negedge clk);
        n_vec++; if (id_ready_o !== 1'b1) begin n_err++; $display("FAIL lu_ready_resume: got %b exp 1", id_ready_o); end
        tick();
        n_vec++; if (ex_valid_o !== 1'b1 || ex_out.rd !== 5'd6 || ex_out.rvfi.rs2_rdata !== 32'd7)
            begin n_err++; $display("FAIL lu_add: got v=%b rd=%0d rs2=%h exp 1/6/7", ex_valid_o, ex_out.rd, ex_out.rvfi.rs2_rdata); end
        n_vec++; if (perf_stall_o !== 4'd1) begin n_err++; $display("FAIL lu_stall_once: got %0d exp 1", perf_stall_o); end
    endtask

    task automatic test_load_x0();
        drive(enc_lw(0, 1), 1);
        tick();
        drive(enc_add(6, 0, 2), 1);
        @(negedge clk);
        n_vec++; if (id_ready_o !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b exp 1", id_ready_o); end
        tick();
        n_vec++; if (ex_valid_o !== 1'b1 || ex_out.rvfi.rs1_rdata !== 32'h0)
            begin n_err++; $display("FAIL x0_read: got v=%b rs1=%h exp 1/0", ex_valid_o, ex_out.rvfi.rs1_rdata); end
        n_vec++; if (perf_stall_o !== 4'd1) begin n_err++; $display("FAIL x0_no_stall: got %0d exp 1", perf_stall_o); end
    endtask

    task automatic test_wb_bypass();
        wb_write(7, 32'h1111);
        drive(enc_add(9, 7, 0), 1);
        wb_load_i = 1; wb_rd_i = 7; wb_data_i = 32'hDEADBEEF;
        tick();
        wb_load_i = 0;
        n_vec++; if (ex_out.rvfi.rs1_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL byp_same_cycle: got %h exp deadbeef", ex_out.rvfi.rs1_rdata); end
        drive(enc_add(9, 7, 7), 1);
        tick();
        n_vec++; if (ex_out.rs1_data !== 32'hDEADBEEF || ex_out.rs2_data !== 32'hDEADBEEF)
            begin n_err++; $display("FAIL byp_landed: got %h/%h exp deadbeef", ex_out.rs1_data, ex_out.rs2_data); end
        drive(enc_add(9, 0, 7), 1);
        wb_load_i = 1; wb_rd_i = 0; wb_data_i = 32'h5A5A;
        tick();
        wb_load_i = 0;
        drive(enc_add(9, 0, 7), 1);
        tick();
        n_vec++; if (ex_out.rvfi.rs1_rdata !== 32'h0 || ex_out.rvfi.rs2_rdata !== 32'hDEADBEEF)
            begin n_err++; $display("FAIL byp_x0: got %h/%h exp 0/deadbeef", ex_out.rvfi.rs1_rdata, ex_out.rvfi.rs2_rdata); end
    endtask

    task automatic test_ex_stall();
        logic [31:0] pc10;
        drive(enc_add(10, 1, 2), 1);
        pc10 = id_in.pc;
        tick();
        ex_ready_i = 0;
        drive(enc_add(11, 1, 2), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (id_ready_o !== 1'b0) begin n_err++; $display("FAIL exs_ready[%0d]: got %b exp 0", i, id_ready_o); end
            tick();
            n_vec++; if (ex_valid_o !== 1'b1 || ex_out.rd !== 5'd10 || ex_out.pc !== pc10)
                begin n_err++; $display("FAIL exs_hold[%0d]: got v=%b rd=%0d pc=%h exp 1/10/%h", i, ex_valid_o, ex_out.rd, ex_out.pc, pc10); end
            n_vec++; if (perf_stall_o !== 4'(m_stall) || perf_flush_o !== 4'(m_flush))
                begin n_err++; $display("FAIL exs_cnt[%0d]: got %0d/%0d exp %0d/%0d", i, perf_stall_o, perf_flush_o, m_stall, m_flush); end
        end
        ex_ready_i = 1;
        tick();
        n_vec++; if (ex_valid_o !== 1'b1 || ex_out.rd !== 5'd11) begin n_err++; $display("FAIL exs_release: got v=%b rd=%0d exp 1/11", ex_valid_o, ex_out.rd); end
    endtask

    task automatic test_flush_hazard();
        drive(enc_lw(5, 1), 1);
        tick();
        drive(enc_add(6, 5, 2), 1);
        flush_i = 1;
        @(negedge clk);
        n_vec++; if (id_ready_o !== 1'b1) begin n_err++; $display("FAIL fl_ready: got %b exp 1", id_ready_o); end
        tick();
        flush_i = 0;
        n_vec++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL fl_valid: got %b exp 0", ex_valid_o); end
        n_vec++; if (perf_flush_o !== 4'd1 || perf_stall_o !== 4'd1)
            begin n_err++; $display("FAIL fl_cnt: got flush=%0d stall=%0d exp 1/1", perf_flush_o, perf_stall_o); end
        drive(enc_add(12, 1, 2), 1);
        tick();
        ex_ready_i = 0; flush_i = 1;
        tick();
        ex_ready_i = 1; flush_i = 0;
        n_vec++; if (ex_valid_o !== 1'b0 || perf_flush_o !== 4'd2)
            begin n_err++; $display("FAIL fl_over_bp: got v=%b flush=%0d exp 0/2", ex_valid_o, perf_flush_o); end
    endtask

    task automatic test_random(input int n);
        bit hold = 0;
        bit exp_rdy;
        for (int i = 0; i < n; i++) begin
            if (!hold) drive(rand_ir(), $urandom_range(0, 7) != 0);
            flush_i    = ($urandom_range(0, 9) == 0);
            ex_ready_i = ($urandom_range(0, 3) != 0);
            wb_load_i  = $urandom_range(0, 1);
            wb_rd_i    = 5'($urandom_range(0, 7));
            wb_data_i  = $urandom;
            @(negedge clk);
            exp_rdy = flush_i | (ex_ready_i & !m_hazard());
            n_vec++; if (id_ready_o !== exp_rdy) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b exp %b", i, id_ready_o, exp_rdy); end
            hold = id_valid_i && !exp_rdy;
            tick();
            n_vec++; if (ex_valid_o !== m_vld) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b exp %b", i, ex_valid_o, m_vld); end
            if (m_vld) begin
                n_vec++; if ({ex_out.rd, ex_out.pc, ex_out.ctrl.mem_read, ex_out.rvfi.inst} !== {m_rd, m_pc, m_ld, m_inst})
                    begin n_err++; $display("FAIL rnd_fields[%0d]: got rd=%0d pc=%h ld=%b ir=%h exp %0d %h %b %h", i, ex_out.rd, ex_out.pc, ex_out.ctrl.mem_read, ex_out.rvfi.inst, m_rd, m_pc, m_ld, m_inst); end
                n_vec++; if ({ex_out.rs1_data, ex_out.rs2_data, ex_out.rvfi.rs1_rdata, ex_out.rvfi.rs2_rdata} !== {m_r1, m_r2, m_r1, m_r2})
                    begin n_err++; $display("FAIL rnd_rdata[%0d]: got %h %h exp %h %h", i, ex_out.rs1_data, ex_out.rs2_data, m_r1, m_r2); end
                n_vec++; if ({ex_out.i_imm, ex_out.s_imm, ex_out.b_imm, ex_out.u_imm, ex_out.j_imm} !== {m_imm[0], m_imm[1], m_imm[2], m_imm[3], m_imm[4]})
                    begin n_err++; $display("FAIL rnd_imm[%0d]: got %h %h %h %h %h exp %h %h %h %h %h", i, ex_out.i_imm, ex_out.s_imm, ex_out.b_imm, ex_out.u_imm, ex_out.j_imm, m_imm[0], m_imm[1], m_imm[2], m_imm[3], m_imm[4]); end
            end
            n_vec++; if (perf_stall_o !== 4'(m_stall) || perf_flush_o !== 4'(m_flush))
                begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d exp %0d/%0d", i, perf_stall_o, perf_flush_o, m_stall, m_flush); end
        end
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        wb_write(7, 32'hCAFE0007);
        drive(enc_add(13, 1, 2), 1);
        tick();
        n_vec++; if (ex_valid_o !== 1'b1) begin n_err++; $display("FAIL ar_pre_valid: got %b exp 1", ex_valid_o); end
        #2 rst = 0;
        #1;
        n_vec++; if (ex_valid_o !== 1'b0 || perf_stall_o !== '0 || perf_flush_o !== '0)
            begin n_err++; $display("FAIL ar_immediate: got v=%b cnt=%0d/%0d exp 0/0/0", ex_valid_o, perf_stall_o, perf_flush_o); end
        n_vec++; if (id_ready_o !== 1'b1) begin n_err++; $display("FAIL ar_ready: got %b exp 1", id_ready_o); end
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        m_reset();
        drive(enc_add(9, 7, 0), 1);
        tick();
        n_vec++; if (ex_valid_o !== 1'b1 || ex_out.rvfi.rs1_rdata !== 32'h0)
            begin n_err++; $display("FAIL ar_regs_cleared: got v=%b rs1=%h exp 1/0", ex_valid_o, ex_out.rvfi.rs1_rdata); end
    endtask

    task automatic test_saturate();
        int exp_c;
        for (int i = 0; i < 20; i++) begin
            drive(enc_lw(5, 1), 1); tick();
            drive(enc_add(6, 5, 5), 1); tick(); tick();
            exp_c = (i + 1 < SAT) ? i + 1 : SAT;
            n_vec++; if (perf_stall_o !== 4'(exp_c)) begin n_err++; $display("FAIL sat_stall[%0d]: got %0d exp %0d", i, perf_stall_o, exp_c); end
        end
        for (int i = 0; i < 20; i++) begin
            drive(enc_add(12, 1, 2), 1); tick();
            flush_i = 1; tick();
            flush_i = 0;
            exp_c = (i + 1 < SAT) ? i + 1 : SAT;
            n_vec++; if (perf_flush_o !== 4'(exp_c)) begin n_err++; $display("FAIL sat_flush[%0d]: got %0d exp %0d", i, perf_flush_o, exp_c); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_x0();
        test_wb_bypass();
        test_ex_stall();
        test_flush_hazard();
        test_random(400);
        test_async_reset();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
